// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank controller.
// Opcodes, FSM states and the default step-count width.
package jk_ctrl_pkg;

    localparam int LEN_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_LOAD  = 3'd2,
        OP_UP    = 3'd3,
        OP_DOWN  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    function automatic logic op_counted(input logic [2:0] op);
        return (op == OP_HOLD) || (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/jk.sv
// Single JK flip-flop with synchronous active-high reset.
// j/k: 00 hold, 01 clear, 10 set, 11 toggle.
module jk (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of JK flip-flops.
// Executes HOLD/CLEAR/LOAD/UP/DOWN one step per EXEC cycle.
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             err
);

    state_e           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] rem;
    logic             err_q;
    logic             accept;
    logic             short_cmd;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             up_acc;
    logic             dn_acc;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign cmd_ready = reset && (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign short_cmd = !op_legal(cmd_op)
                    || (op_counted(cmd_op) && (cmd_len == '0));

    assign busy = reset && (state == ST_EXEC);
    assign done = reset && (state == ST_DONE);
    assign err  = done && err_q;
    assign tc   = busy && (((op_q == OP_UP) && (&count))
                        || ((op_q == OP_DOWN) && (~|count)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            rem    <= '0;
            op_q   <= OP_HOLD;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        err_q  <= !op_legal(cmd_op);
                        if (short_cmd) begin
                            state <= ST_DONE;
                            rem   <= '0;
                        end else begin
                            state <= ST_EXEC;
                            rem   <= op_counted(cmd_op) ? cmd_len : LEN_W'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    rem <= rem - 1'b1;
                    if (rem == LEN_W'(1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ripple toggle enables: bit i flips when all lower bits are 1 (up) / 0 (down)
    always_comb begin
        up_acc = 1'b1;
        dn_acc = 1'b1;
        up_t   = '0;
        dn_t   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = up_acc;
            dn_t[i] = dn_acc;
            up_acc  = up_acc & count[i];
            dn_acc  = dn_acc & ~count[i];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (!reset) begin
            k = '1;
        end else if (state == ST_EXEC) begin
            case (op_q)
                OP_CLEAR: k = '1;
                OP_LOAD: begin
                    j = data_q;
                    k = ~data_q;
                end
                OP_UP: begin
                    j = up_t;
                    k = up_t;
                end
                OP_DOWN: begin
                    j = dn_t;
                    k = dn_t;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk u_jk (
            .clk   (clk),
            .reset (1'b0),
            .j     (j[i]),
            .k     (k[i]),
            .q     (count[i])
        );
    end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl (WIDTH=4).
// Per-cycle expectations are queued at accept and popped each negedge.
module tb_jk_bank_ctrl;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [2:0]       cmd_op = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_ready;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc;
    logic             err;

    jk_bank_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .tc        (tc),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             bsy;
        logic             dn;
        logic             er;
        logic             t;
    } exp_t;

    exp_t             sbq[$];
    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] mc = '0;
    logic             hold_valid = 1'b0;
    logic             prev_low = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] step(input logic [2:0] op,
                                              input logic [WIDTH-1:0] c,
                                              input logic [WIDTH-1:0] d);
        case (op)
            3'd1:    return '0;
            3'd2:    return d;
            3'd3:    return c + 1'b1;
            3'd4:    return c - 1'b1;
            default: return c;
        endcase
    endfunction

    task automatic push_cmd();
        logic [2:0]       op;
        logic [WIDTH-1:0] d;
        int               n;
        op = cmd_op;
        d  = cmd_data;
        n  = int'(cmd_len);
        if (op > 3'd4) begin
            sbq.push_back('{mc, 1'b0, 1'b1, 1'b1, 1'b0});
        end else if ((op == 3'd0 || op == 3'd3 || op == 3'd4) && n == 0) begin
            sbq.push_back('{mc, 1'b0, 1'b1, 1'b0, 1'b0});
        end else begin
            if (op == 3'd1 || op == 3'd2) n = 1;
            for (int s = 0; s < n; s++) begin
                sbq.push_back('{mc, 1'b1, 1'b0, 1'b0,
                    (op == 3'd3 && mc == 4'hF) || (op == 3'd4 && mc == 4'h0)});
                mc = step(op, mc, d);
            end
            sbq.push_back('{mc, 1'b0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic acc;
        @(negedge clk);
        acc = 1'b0;
        if (!reset) begin
            sbq.delete();
            mc = '0;
            if (prev_low) check("rst_count", count, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_tc", tc, 0);
            check("rst_ready", cmd_ready, 0);
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("count", count, e.cnt);
                check("busy", busy, e.bsy);
                check("done", done, e.dn);
                check("err", err, e.er);
                check("tc", tc, e.t);
                check("ready", cmd_ready, 0);
            end else begin
                check("idle_count", count, mc);
                check("idle_ready", cmd_ready, 1);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_err", err, 0);
            end
            acc = cmd_valid && cmd_ready;
            if (acc) push_cmd();
        end
        @(posedge clk);
        #1;
        if (acc && !hold_valid) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (sbq.size() == 0 && !cmd_valid && cmd_ready) return;
        end
        check("timeout", 1, 0);
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] d,
                        input logic [LEN_W-1:0] len);
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = len;
        cmd_valid = 1'b1;
        drain();
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;

        send(3'd3, 4'h0, 8'd5);
        send(3'd2, 4'hE, 8'd0);
        send(3'd3, 4'h0, 8'd3);
        send(3'd2, 4'h1, 8'd0);
        send(3'd4, 4'h0, 8'd2);
        send(3'd1, 4'h0, 8'd0);

        // Abort an UP 10 during its third EXEC cycle
        cmd_op    = 3'd3;
        cmd_len   = 8'd10;
        cmd_valid = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        drain();
        send(3'd3, 4'h0, 8'd1);

        // Valid held while busy; the illegal op waits for IDLE
        cmd_op     = 3'd3;
        cmd_len    = 8'd3;
        cmd_valid  = 1'b1;
        hold_valid = 1'b1;
        cycle();
        cmd_op     = 3'd6;
        hold_valid = 1'b0;
        drain();

        send(3'd0, 4'h0, 8'd4);
        send(3'd3, 4'h0, 8'd0);
        send(3'd7, 4'h5, 8'd2);
        send(3'd4, 4'h0, 8'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
